// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped prescaled 32-bit timer with compare match and interrupt
module mmio_timer #(
    parameter logic [11:0] BASE_ADR   = 12'h100,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] adr,
    input  logic [31:0] data_in,
    input  logic [3:0]  WE,
    input  logic        EN,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        irq
);

    logic                  ctrl_en;
    logic                  ctrl_periodic;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic                  sel;
    logic [2:0]            off;
    logic                  rd;
    logic                  wr;
    logic                  wr_ctrl;
    logic                  wr_pre;
    logic                  wr_count;
    logic                  wr_cmp;
    logic                  w1c_match;
    logic                  tick;
    logic                  cnt_match;
    logic [31:0]           rdata;
    logic [31:0]           count_wdata;
    logic [31:0]           cmp_wdata;
    logic [PRESCALE_W-1:0] pre_wdata;

    assign sel       = EN && (adr[11:3] == BASE_ADR[11:3]);
    assign off       = adr[2:0];
    assign rd        = sel && (WE == 4'b0000);
    assign wr        = sel && (WE != 4'b0000);
    assign wr_ctrl   = wr && (off == 3'd0);
    assign wr_pre    = wr && (off == 3'd1);
    assign wr_count  = wr && (off == 3'd2);
    assign wr_cmp    = wr && (off == 3'd3);
    assign w1c_match = wr && (off == 3'd4) && WE[0] && data_in[0];

    assign tick      = ctrl_en && (pre_cnt == prescale);
    assign cnt_match = (count == compare);

    assign irq       = match & ctrl_irq_en;

    // Byte-lane merges of bus data into the current register contents
    always_comb begin
        count_wdata = count;
        cmp_wdata   = compare;
        for (int i = 0; i < 4; i++) begin
            if (WE[i]) begin
                count_wdata[i*8 +: 8] = data_in[i*8 +: 8];
                cmp_wdata[i*8 +: 8]   = data_in[i*8 +: 8];
            end
        end
    end

    always_comb begin
        pre_wdata = prescale;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (WE[i/8]) begin
                pre_wdata[i] = data_in[i];
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (off)
            3'd0:    rdata = {29'd0, ctrl_irq_en, ctrl_periodic, ctrl_en};
            3'd1:    rdata = 32'(prescale);
            3'd2:    rdata = count;
            3'd3:    rdata = compare;
            3'd4:    rdata = {31'd0, match};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            prescale      <= '0;
            pre_cnt       <= '0;
            count         <= 32'd0;
            compare       <= 32'hFFFF_FFFF;
            match         <= 1'b0;
            data_out      <= 32'd0;
            hit           <= 1'b0;
        end else begin
            hit <= sel;
            if (rd) begin
                data_out <= rdata;
            end

            // Any CTRL/PRESCALE write restarts the prescale phase
            if (wr_ctrl || wr_pre || !ctrl_en || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (wr_count) begin
                count <= count_wdata;
            end else if (tick) begin
                if (cnt_match) begin
                    if (ctrl_periodic) begin
                        count <= 32'd0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr_ctrl && WE[0]) begin
                ctrl_en       <= data_in[0];
                ctrl_periodic <= data_in[1];
                ctrl_irq_en   <= data_in[2];
            end else if (tick && cnt_match && !ctrl_periodic) begin
                ctrl_en <= 1'b0;
            end

            if (wr_pre) begin
                prescale <= pre_wdata;
            end
            if (wr_cmp) begin
                compare <= cmp_wdata;
            end

            // A match raised this cycle wins over a software clear
            if (tick && cnt_match) begin
                match <= 1'b1;
            end else if (w1c_match) begin
                match <= 1'b0;
            end
        end
    end

endmodule
